// File: rtl/access_lockout_ctrl_if.sv
// Attempt/status bundle between the password checker side and access_lockout_ctrl.
// master drives submit/match and observes status; slave is the controller side.
interface access_lockout_ctrl_if #(
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FC_W = $clog2(MAX_FAILS + 1);

  logic            submit;
  logic            match;
  logic            unlocked;
  logic            locked_out;
  logic [FC_W-1:0] fail_cnt;
  logic            attempt_ok;
  logic            attempt_bad;
  logic [1:0]      state_dbg;

  modport master (
    output submit, match,
    input  unlocked, locked_out, fail_cnt, attempt_ok, attempt_bad, state_dbg
  );

  modport slave (
    input  submit, match,
    output unlocked, locked_out, fail_cnt, attempt_ok, attempt_bad, state_dbg
  );
endinterface

// File: rtl/access_lockout_ctrl.sv
// Timed unlock / lockout controller driven by the password checker's match flag.
// Define SUBMIT_EDGE_EN to treat submit as a button level (rising-edge qualified).
module access_lockout_ctrl #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input logic                  clk,
  input logic                  rst,
  access_lockout_ctrl_if.slave bus
);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned FC_W    = $clog2(MAX_FAILS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OPEN = 2'b01,
    LOCK = 2'b10
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [FC_W-1:0]  fail_next;
  logic             sub_evt;

  assign fail_next = bus.fail_cnt + FC_W'(1);

`ifdef SUBMIT_EDGE_EN
  // submit_q resets high so a button held through reset release is not an attempt.
  logic submit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) submit_q <= 1'b1;
    else     submit_q <= bus.submit;
  end

  assign sub_evt = bus.submit & ~submit_q;
`else
  assign sub_evt = bus.submit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      bus.fail_cnt    <= '0;
      bus.unlocked    <= 1'b0;
      bus.locked_out  <= 1'b0;
      bus.attempt_ok  <= 1'b0;
      bus.attempt_bad <= 1'b0;
      bus.state_dbg   <= IDLE;
    end else begin
      bus.attempt_ok  <= 1'b0;
      bus.attempt_bad <= 1'b0;
      case (state)
        IDLE: begin
          if (sub_evt) begin
            if (bus.match) begin
              state          <= OPEN;
              timer          <= TMR_W'(UNLOCK_CYCLES - 1);
              bus.fail_cnt   <= '0;
              bus.attempt_ok <= 1'b1;
              bus.unlocked   <= 1'b1;
              bus.state_dbg  <= OPEN;
            end else begin
              bus.attempt_bad <= 1'b1;
              bus.fail_cnt    <= fail_next;
              if (fail_next == FC_W'(MAX_FAILS)) begin
                state          <= LOCK;
                timer          <= TMR_W'(LOCKOUT_CYCLES - 1);
                bus.locked_out <= 1'b1;
                bus.state_dbg  <= LOCK;
              end
            end
          end
        end
        OPEN: begin
          if (timer == '0) begin
            state         <= IDLE;
            bus.unlocked  <= 1'b0;
            bus.state_dbg <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        LOCK: begin
          if (timer == '0) begin
            state          <= IDLE;
            bus.fail_cnt   <= '0;
            bus.locked_out <= 1'b0;
            bus.state_dbg  <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state          <= IDLE;
          timer          <= '0;
          bus.fail_cnt   <= '0;
          bus.unlocked   <= 1'b0;
          bus.locked_out <= 1'b0;
          bus.state_dbg  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_access_lockout_ctrl.sv
// Directed bench for access_lockout_ctrl with MAX_FAILS=3, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8.
// Status is packed as {unlocked, locked_out, fail_cnt[1:0], attempt_ok, attempt_bad, state_dbg[1:0]}.
module tb_access_lockout_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  access_lockout_ctrl_if #(.MAX_FAILS(3)) bus ();

  access_lockout_ctrl #(
    .MAX_FAILS(3),
    .UNLOCK_CYCLES(4),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       submit;
    logic       match;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] pack(logic ul, logic lo, logic [1:0] fc,
                                      logic ok, logic bad, logic [1:0] dbg);
    return {ul, lo, fc, ok, bad, dbg};
  endfunction

  function automatic vec_t v(logic s, logic m, logic ul, logic lo, logic [1:0] fc,
                             logic ok, logic bad, logic [1:0] dbg);
    vec_t r;
    r.submit = s;
    r.match  = m;
    r.exp    = pack(ul, lo, fc, ok, bad, dbg);
    return r;
  endfunction

  function automatic logic [7:0] status();
    return {bus.unlocked, bus.locked_out, bus.fail_cnt, bus.attempt_ok,
            bus.attempt_bad, bus.state_dbg};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = status();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (ul lo fc ok bad dbg)", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same offset.
  task automatic step(input logic s, input logic m);
    bus.submit = s;
    bus.match  = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.submit = 1'b0;
    bus.match  = 1'b0;

    // Test 2: good attempt, submits during OPEN ignored
    vecs.push_back(v(1,1, 1,0,2'd0,1,0,2'b01));
    vecs.push_back(v(1,1, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(1,0, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(1,1, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(0,0, 0,0,2'd0,0,0,2'b00));
    // Test 3: three bad attempts -> 8-cycle lockout, good submit ignored
    vecs.push_back(v(1,0, 0,0,2'd1,0,1,2'b00));
    vecs.push_back(v(0,0, 0,0,2'd1,0,0,2'b00));
    vecs.push_back(v(1,0, 0,0,2'd2,0,1,2'b00));
    vecs.push_back(v(0,0, 0,0,2'd2,0,0,2'b00));
    vecs.push_back(v(1,0, 0,1,2'd3,0,1,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(1,1, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,1,2'd3,0,0,2'b10));
    vecs.push_back(v(0,0, 0,0,2'd0,0,0,2'b00));
    // Test 4: two bad then good, accepted in first IDLE cycle after lockout
    vecs.push_back(v(1,0, 0,0,2'd1,0,1,2'b00));
    vecs.push_back(v(0,0, 0,0,2'd1,0,0,2'b00));
    vecs.push_back(v(1,0, 0,0,2'd2,0,1,2'b00));
    vecs.push_back(v(0,0, 0,0,2'd2,0,0,2'b00));
    vecs.push_back(v(1,1, 1,0,2'd0,1,0,2'b01));
    vecs.push_back(v(0,0, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(0,0, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(0,0, 1,0,2'd0,0,0,2'b01));
    vecs.push_back(v(0,0, 0,0,2'd0,0,0,2'b00));
    // first IDLE cycle after OPEN expiry accepts an attempt
    vecs.push_back(v(1,0, 0,0,2'd1,0,1,2'b00));
    vecs.push_back(v(0,0, 0,0,2'd1,0,0,2'b00));

    // Test 1: reset held, then released -> stays IDLE
    #1;
    check("reset_hold", 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_3cyc", 8'h00);
    rst = 1'b0;
    step(0, 0);
    step(0, 0);
    check("post_reset_idle", 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].submit, vecs[i].match);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Test 5: reset mid-LOCK clears outputs without a clock edge
    step(1, 0);
    check("pre_lock_fc2", pack(0,0,2'd2,0,1,2'b00));
    step(0, 0);
    step(1, 0);
    check("lock_entry", pack(0,1,2'd3,0,1,2'b10));
    step(0, 0);
    step(0, 0);
    step(0, 0);
    check("lock_cycle4", pack(0,1,2'd3,0,0,2'b10));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_mid_lock", 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_mid_lock_held", 8'h00);
    rst = 1'b0;
    step(0, 0);
    check("idle_after_lock_reset", 8'h00);
    step(1, 0);
    check("bad_after_reset", pack(0,0,2'd1,0,1,2'b00));
    step(0, 0);

    // Test 6: submit held high for 5 cycles with match=0
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0);
`ifdef SUBMIT_EDGE_EN
    step(1, 0); check("held_c1", pack(0,0,2'd1,0,1,2'b00));
    step(1, 0); check("held_c2", pack(0,0,2'd1,0,0,2'b00));
    step(1, 0); check("held_c3", pack(0,0,2'd1,0,0,2'b00));
    step(1, 0); check("held_c4", pack(0,0,2'd1,0,0,2'b00));
    step(1, 0); check("held_c5", pack(0,0,2'd1,0,0,2'b00));
    step(0, 0); check("held_release", pack(0,0,2'd1,0,0,2'b00));
`else
    step(1, 0); check("held_c1", pack(0,0,2'd1,0,1,2'b00));
    step(1, 0); check("held_c2", pack(0,0,2'd2,0,1,2'b00));
    step(1, 0); check("held_c3", pack(0,1,2'd3,0,1,2'b10));
    step(1, 0); check("held_c4", pack(0,1,2'd3,0,0,2'b10));
    step(1, 0); check("held_c5", pack(0,1,2'd3,0,0,2'b10));
    step(0, 0); check("held_release", pack(0,1,2'd3,0,0,2'b10));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
